// File: rtl/fifo_1x1_if.sv
// Producer/consumer handshake bundle for fifo_1x1.
// The slave modport is the FIFO side; the master modport is the user side.
interface fifo_1x1_if #(
  parameter int unsigned DATA_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_en;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;

  modport slave (
    input  wr_data, wr_en, rd_en,
    output rd_data, rd_valid, full, empty
  );

  modport master (
    output wr_data, wr_en, rd_en,
    input  rd_data, rd_valid, full, empty
  );
endinterface

// File: rtl/fifo_1x1.sv
// Single-clock FIFO with a registered read port and 1-cycle read latency.
// Pointers wrap by explicit compare, so any depth >= 2 works.
module fifo_1x1 #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  fifo_1x1_if.slave  bus
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  logic                  w_full, w_empty, w_wr_acc, w_rd_acc;
  logic [AW-1:0]         w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CW-1:0]         w_count_nxt;

  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = bus.wr_en && !w_full;
  assign w_rd_acc = bus.rd_en && !w_empty;

  always_comb begin
    w_wr_ptr_nxt = (r_wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
    w_rd_ptr_nxt = (r_rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
    w_count_nxt  = r_count;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is intentionally not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_rd_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_rd_acc) begin
        r_rd_ptr  <= w_rd_ptr_nxt;
        r_rd_data <= r_mem[r_rd_ptr];
      end
    end
  end

  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
endmodule

// File: tb/tb_fifo_1x1.sv
// Directed bench for fifo_1x1: reset, fill, drain, streaming wrap, edge cases.
module tb_fifo_1x1;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  fifo_1x1_if #(.DATA_WIDTH(1)) bus ();

  fifo_1x1 #(.DATA_WIDTH(1), .FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs, take one rising edge, settle 1 ns past it.
  task automatic cyc(input logic wr, input logic wd, input logic rd);
    bus.wr_en   = wr;
    bus.wr_data = wd;
    bus.rd_en   = rd;
    @(posedge clk);
    #1;
  endtask

  logic q[$];
  logic exp_d;
  logic fill_pat [8];
  logic full_pat [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    fill_pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    full_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bus.wr_en = 1'b0; bus.wr_data = 1'b0; bus.rd_en = 1'b0;
    reset = 1'b0;

    // Reset asserted between edges must act without a clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_valid", bus.rd_valid, 0);
    check("rst_data", bus.rd_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    cyc(1, 1, 0);
    check("first_wr_empty", bus.empty, 0);
    check("first_wr_count", dut.r_count, 1);
    cyc(0, 0, 1);
    check("first_rd_valid", bus.rd_valid, 1);
    check("first_rd_data", bus.rd_data, 1);
    check("first_rd_empty", bus.empty, 1);
    cyc(0, 0, 0);
    check("idle_valid", bus.rd_valid, 0);

    // Fill with 0,1,0,1,...
    for (int i = 0; i < 8; i++) begin
      cyc(1, fill_pat[i], 0);
      check("fill_count", dut.r_count, i + 1);
      check("fill_full", bus.full, (i == 7) ? 1 : 0);
    end
    cyc(1, 1, 0);
    check("overwr_count", dut.r_count, 8);
    check("overwr_full", bus.full, 1);

    // Drain; the rejected 9th write must not appear.
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1);
      check("drain_valid", bus.rd_valid, 1);
      check("drain_data", bus.rd_data, fill_pat[i]);
      check("drain_empty", bus.empty, (i == 7) ? 1 : 0);
    end
    cyc(0, 0, 1);
    check("underrd_valid", bus.rd_valid, 0);
    check("underrd_data", bus.rd_data, 1);

    // Preload 4, then stream 20 cycles so both pointers wrap.
    q.delete();
    for (int i = 0; i < 4; i++) begin
      cyc(1, (i == 1 || i == 2) ? 1'b0 : 1'b1, 0);
      q.push_back((i == 1 || i == 2) ? 1'b0 : 1'b1);
    end
    check("pre_count", dut.r_count, 4);
    for (int i = 0; i < 20; i++) begin
      exp_d = q.pop_front();
      q.push_back(i[0]);
      cyc(1, i[0], 1);
      check("strm_valid", bus.rd_valid, 1);
      check("strm_data", bus.rd_data, exp_d);
      check("strm_count", dut.r_count, 4);
      check("strm_full", bus.full, 0);
      check("strm_empty", bus.empty, 0);
    end
    for (int i = 0; i < 4; i++) begin
      exp_d = q.pop_front();
      cyc(0, 0, 1);
      check("strm_tail", bus.rd_data, exp_d);
    end
    check("strm_done_empty", bus.empty, 1);

    // Full with simultaneous write and read.
    for (int i = 0; i < 8; i++) cyc(1, full_pat[i], 0);
    check("full2_full", bus.full, 1);
    cyc(1, 1, 1);
    check("fullrw_valid", bus.rd_valid, 1);
    check("fullrw_data", bus.rd_data, full_pat[0]);
    check("fullrw_count", dut.r_count, 7);
    check("fullrw_full", bus.full, 0);
    for (int i = 1; i < 8; i++) begin
      cyc(0, 0, 1);
      check("fullrw_drain", bus.rd_data, full_pat[i]);
    end
    check("fullrw_empty", bus.empty, 1);

    // Empty with simultaneous write and read: no fall-through.
    cyc(1, 1, 1);
    check("emptyrw_valid", bus.rd_valid, 0);
    check("emptyrw_count", dut.r_count, 1);
    check("emptyrw_empty", bus.empty, 0);
    cyc(0, 0, 1);
    check("emptyrw_rd_valid", bus.rd_valid, 1);
    check("emptyrw_rd_data", bus.rd_data, 1);

    // Reset pulse mid-fill discards everything.
    for (int i = 0; i < 5; i++) cyc(1, 1, 0);
    check("midfill_count", dut.r_count, 5);
    bus.wr_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("midrst_empty", bus.empty, 1);
    check("midrst_data", bus.rd_data, 0);
    #1 reset = 1'b0;
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    check("post_count", dut.r_count, 2);
    cyc(0, 0, 1);
    check("post_rd0_valid", bus.rd_valid, 1);
    check("post_rd0_data", bus.rd_data, 0);
    cyc(0, 0, 1);
    check("post_rd1_data", bus.rd_data, 1);
    cyc(0, 0, 1);
    check("post_rd2_valid", bus.rd_valid, 0);
    check("post_empty", bus.empty, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fifo_1x1.md
Name: fifo_1x1

Overview:
Single-clock, synchronous first-in/first-out buffer with a 1-bit default data path and a default depth of 8 entries.
- Decouples a producer and a consumer that run in the same clock domain.
- Provides full/empty status flags and a registered read-data output with a valid strobe.

Parameters:
DATA_WIDTH, 1, width of each stored word in bits (>=1).
FIFO_DEPTH, 8, number of storage entries (>=2; need not be a power of two).

Ports:
clk  input  1  single clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
wr_data  input  DATA_WIDTH  word to write.
wr_en  input  1  write request.
rd_data  output  DATA_WIDTH  registered read data.
rd_en  input  1  read request.
rd_valid  output  1  rd_data holds a newly popped word this cycle.
full  output  1  FIFO holds FIFO_DEPTH words.
empty  output  1  FIFO holds 0 words.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high (port "reset"). All outputs are registered, or derived combinationally from registered state only.
- State:
  - wr_ptr, rd_ptr, each ceil(log2(FIFO_DEPTH)) bits.
  - count, 0..FIFO_DEPTH, ceil(log2(FIFO_DEPTH+1)) bits.
  - memory of FIFO_DEPTH x DATA_WIDTH.
- Reset (asserted asynchronously, held while high): wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, empty=1, full=0. Memory contents are not cleared.
- Flags: empty = (count==0); full = (count==FIFO_DEPTH). Both are valid in the same cycle count changes.
- Write accept: wr_en && !full, evaluated on pre-edge state. On accept, mem[wr_ptr] <= wr_data and wr_ptr advances.
- Write when full: ignored silently. No state change, no error flag.
- Read accept: rd_en && !empty, evaluated on pre-edge state. On accept:
  - rd_data <= mem[rd_ptr] and rd_ptr advances.
  - rd_valid=1 in the following cycle (1-cycle latency).
- Read when empty: ignored. rd_valid=0 and rd_data holds its previous value.
- When no read is accepted, rd_valid=0 and rd_data holds.
- Pointer wrap: when a pointer equals FIFO_DEPTH-1 and advances, it returns to 0. This explicit compare is required so non-power-of-two depths work.
- count update:
  - +1 on write-only accept.
  - -1 on read-only accept.
  - unchanged when both or neither are accepted.
- Simultaneous wr_en and rd_en:
  - Not empty and not full: both accepted, count unchanged.
  - Full: read accepted, write rejected, count decrements.
  - Empty: write accepted, read rejected, count increments. No same-cycle fall-through; the word becomes readable next cycle.
- Ordering: words leave in exactly the order accepted. No loss or duplication apart from rejected writes.
- Reset mid-operation: all stored words are discarded. The FIFO reports empty immediately, without waiting for a clock edge.

Test Plan:
- Reset:
  - Stimulus: assert reset between clock edges.
  - Required: empty=1, full=0, rd_valid=0, rd_data=0 asynchronously. After release, first write of 1 gives empty=0 next edge.
- Fill:
  - Stimulus: wr_en=1, rd_en=0, write alternating 0,1,0,1,0,1,0,1 (8 words).
  - Required: full=1 after 8th edge, count=8. A 9th write (value 1) leaves count=8 and full=1.
- Drain:
  - Stimulus: from full, rd_en=1 for 8 cycles.
  - Required: rd_valid=1 each following cycle with rd_data=0,1,0,1,0,1,0,1. empty=1 after 8th read. The 9th read gives rd_valid=0 and rd_data held at 1.
- Streaming with wrap:
  - Stimulus: 4 words pre-loaded, then wr_en=rd_en=1 for 20 cycles with toggling wr_data.
  - Required: count stays 4, order preserved across pointer wrap, full=0 and empty=0 throughout.
- Full/empty edge cases:
  - Full with wr_en=rd_en=1: one word popped, count becomes 7, new word not stored.
  - Empty with wr_en=rd_en=1: rd_valid=0 next cycle, count becomes 1.
- Reset mid-fill:
  - Stimulus: after 5 writes, pulse reset for 2 ns.
  - Required: empty=1 immediately. Subsequent reads return only words written after reset.
